// File: rtl/freq_note_pkg.sv
// Shared constants for the pitch quantiser: frequency format, octave-6 note
// table and the FSM state encoding.
package freq_note_pkg;

  localparam int FRAC_BITS = 20;

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_B  = 4'd11;
  localparam logic [2:0] OCT_TOP = 3'd7;
  localparam logic [2:0] OCT_REF = 3'd6;

  // Octave-6 equal-tempered frequencies, Hz * 2^FRAC_BITS; index 0 = C6.
  localparam logic [11:0][31:0] NOTE_TABLE = {
    32'h7B788802, 32'h748A7B12, 32'h6E000000, 32'h67D3802A,
    32'h61FFB539, 32'h5C7FA49F, 32'h574E9B58, 32'h526829E4,
    32'h4DC82080, 32'h496A8B8F, 32'h454BB03A, 32'h41680943
  };

  // C7: upper neighbour of B6, one bit wider than the table entries.
  localparam logic [32:0] NOTE_T12 = {NOTE_TABLE[0], 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NORM   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_ROUND  = 2'd3
  } state_e;

endpackage

// File: rtl/note_table_rom.sv
// Combinational octave-6 note table lookup; indices above 11 read as zero.
// Also used by the downstream scale selector so both stages agree bit-for-bit.
module note_table_rom
  import freq_note_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [31:0] freq_o
);

  always_comb begin
    freq_o = '0;
    for (int i = 0; i < 12; i++) begin
      if (idx_i == 4'(i)) freq_o = NOTE_TABLE[i];
    end
  end

endmodule

// File: rtl/freq_to_note.sv
// Quantises a measured frequency to the nearest equal-tempered semitone by
// normalising into octave 6, searching the note table, then rounding.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | result stable, done=1, waiting for start
// ST_NORM   | shift f into [C6, C7) one octave per cycle, or clamp low
// ST_SEARCH | walk idx up while f >= T[idx+1]
// ST_ROUND  | pick nearer of T[idx]/T[idx+1], register result, pulse valid
module freq_to_note
  import freq_note_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] freq_in,
  input  logic        start,
  output logic        done,
  output logic        note_valid,
  output logic [3:0]  note_name,
  output logic [2:0]  note_octave,
  output logic        greater,
  output logic        in_range
);

  state_e      state_q, state_d;
  logic [31:0] f_q, f_d;
  logic [2:0]  oct_q, oct_d;
  logic [3:0]  idx_q, idx_d;
  logic        clamp_q, clamp_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [3:0]  name_q, name_d;
  logic [2:0]  octave_q, octave_d;
  logic        greater_q, greater_d;
  logic        in_range_q, in_range_d;

  logic [3:0]  idx_hi;
  logic [31:0] rom_lo, rom_hi;
  logic [32:0] f_ext, t_lo, t_hi, dlo, dhi;

  assign idx_hi = idx_q + 4'd1;

  note_table_rom u_rom_lo (
    .idx_i  (idx_q),
    .freq_o (rom_lo)
  );

  note_table_rom u_rom_hi (
    .idx_i  (idx_hi),
    .freq_o (rom_hi)
  );

  assign f_ext = {1'b0, f_q};
  assign t_lo  = {1'b0, rom_lo};
  assign t_hi  = (idx_q == NOTE_B) ? NOTE_T12 : {1'b0, rom_hi};
  assign dlo   = f_ext - t_lo;
  assign dhi   = t_hi - f_ext;

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    oct_d      = oct_q;
    idx_d      = idx_q;
    clamp_d    = clamp_q;
    done_d     = done_q;
    valid_d    = 1'b0;
    name_d     = name_q;
    octave_d   = octave_q;
    greater_d  = greater_q;
    in_range_d = in_range_q;

    case (state_q)
      ST_IDLE: ;

      ST_NORM: begin
        if (f_ext >= NOTE_T12) begin
          f_d   = {1'b0, f_q[31:1]};
          oct_d = OCT_TOP;
        end else if (f_q < NOTE_TABLE[0]) begin
          if (oct_q != 3'd0) begin
            f_d   = {f_q[30:0], 1'b0};
            oct_d = oct_q - 3'd1;
          end else begin
            clamp_d = 1'b1;
            state_d = ST_ROUND;
          end
        end else begin
          idx_d   = 4'd0;
          state_d = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        if ((idx_q < NOTE_B) && (f_ext >= t_hi)) begin
          idx_d = idx_q + 4'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (clamp_q) begin
          name_d     = NOTE_C;
          octave_d   = 3'd0;
          greater_d  = 1'b0;
          in_range_d = 1'b0;
        end else if (dhi < dlo) begin
          greater_d = 1'b0;
          if (idx_q == NOTE_B) begin
            // B rounding up wraps to C of the next octave, unless already at the top
            if (oct_q == OCT_TOP) begin
              name_d     = NOTE_B;
              octave_d   = OCT_TOP;
              greater_d  = 1'b1;
              in_range_d = 1'b0;
            end else begin
              name_d     = NOTE_C;
              octave_d   = oct_q + 3'd1;
              in_range_d = 1'b1;
            end
          end else begin
            name_d     = idx_q + 4'd1;
            octave_d   = oct_q;
            in_range_d = 1'b1;
          end
        end else begin
          name_d     = idx_q;
          octave_d   = oct_q;
          greater_d  = (dlo != 33'd0);
          in_range_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new request always wins over an in-flight conversion; ROUND still emits.
    if (start) begin
      f_d     = freq_in;
      oct_d   = OCT_REF;
      idx_d   = 4'd0;
      done_d  = 1'b0;
      clamp_d = (freq_in == 32'd0);
      state_d = (freq_in == 32'd0) ? ST_ROUND : ST_NORM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      f_q        <= '0;
      oct_q      <= '0;
      idx_q      <= '0;
      clamp_q    <= 1'b0;
      done_q     <= 1'b1;
      valid_q    <= 1'b0;
      name_q     <= '0;
      octave_q   <= '0;
      greater_q  <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      oct_q      <= oct_d;
      idx_q      <= idx_d;
      clamp_q    <= clamp_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      name_q     <= name_d;
      octave_q   <= octave_d;
      greater_q  <= greater_d;
      in_range_q <= in_range_d;
    end
  end

  assign done        = done_q;
  assign note_valid  = valid_q;
  assign note_name   = name_q;
  assign note_octave = octave_q;
  assign greater     = greater_q;
  assign in_range    = in_range_q;

endmodule

// File: tb/tb_freq_to_note.sv
// Self-checking bench for freq_to_note: directed spec points, random
// frequencies against a flat 97-note reference list, restart/reset/handshake.
module tb_freq_to_note;

  logic        clk;
  logic        reset_n;
  logic [31:0] freq_in;
  logic        start;
  logic        done;
  logic        note_valid;
  logic [3:0]  note_name;
  logic [2:0]  note_octave;
  logic        greater;
  logic        in_range;

  int checks = 0;
  int errors = 0;

  freq_to_note dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .freq_in     (freq_in),
    .start       (start),
    .done        (done),
    .note_valid  (note_valid),
    .note_name   (note_name),
    .note_octave (note_octave),
    .greater     (greater),
    .in_range    (in_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] TB_T [12] = '{
    32'h41680943, 32'h454BB03A, 32'h496A8B8F, 32'h4DC82080,
    32'h526829E4, 32'h574E9B58, 32'h5C7FA49F, 32'h61FFB539,
    32'h67D3802A, 32'h6E000000, 32'h748A7B12, 32'h7B788802
  };

  // Note k (k = 12*oct + name, 0..96) scaled by 64 so every octave is an integer.
  function automatic logic [63:0] note_val(input int k);
    return 64'(TB_T[k % 12]) << (k / 12);
  endfunction

  // Returns {name, octave, greater, in_range}.
  function automatic logic [8:0] ref_note(input logic [31:0] fin);
    logic [63:0] x, lo, hi;
    int k;
    if (fin == 32'd0) return 9'd0;
    // Inputs at or above C7 lose their LSB in the hardware octave shift.
    if (fin >= 32'h82D01286) x = 64'(fin >> 1) << 7;
    else                     x = 64'(fin) << 6;
    if (x < note_val(0)) return 9'd0;
    k = 0;
    for (int j = 1; j < 96; j++) if (note_val(j) <= x) k = j;
    lo = note_val(k);
    hi = note_val(k + 1);
    if ((hi - x) < (x - lo)) begin
      if (k + 1 == 96) return {4'd11, 3'd7, 1'b1, 1'b0};
      return {4'((k + 1) % 12), 3'((k + 1) / 12), 1'b0, 1'b1};
    end
    return {4'(k % 12), 3'(k / 12), (x != lo), 1'b1};
  endfunction

  function automatic logic [8:0] observed();
    return {note_name, note_octave, greater, in_range};
  endfunction

  // Issue one start and wait (bounded) for note_valid; lat counts negedges.
  task automatic convert(input logic [31:0] fin, output int lat, output bit got,
                         output bit busy_seen);
    @(negedge clk);
    freq_in = fin;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    lat       = 1;
    got       = 1'b0;
    busy_seen = (done == 1'b0);
    while (!got && lat < 40) begin
      if (note_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (observed() !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", observed(), 9'd0);
    end
    checks++;
    if ({done, note_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_done_valid: got %b expected 10", {done, note_valid});
    end
  endtask

  task automatic test_directed();
    logic [31:0] fin [6] = '{32'h1B800000, 32'h1BD00000, 32'h1CC00000,
                             32'h7F800000, 32'h00000000, 32'hFFFFFFFF};
    logic [8:0]  exp [6] = '{{4'd9, 3'd4, 1'b0, 1'b1}, {4'd9, 3'd4, 1'b1, 1'b1},
                             {4'd10, 3'd4, 1'b0, 1'b1}, {4'd0, 3'd7, 1'b0, 1'b1},
                             {4'd0, 3'd0, 1'b0, 1'b0}, {4'd11, 3'd7, 1'b1, 1'b0}};
    int lat;
    bit got, busy;
    for (int i = 0; i < 6; i++) begin
      convert(fin[i], lat, got, busy);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: no note_valid for %h within %0d cycles", i, fin[i], lat);
      end else if (observed() !== exp[i] || !busy) begin
        errors++;
        $display("FAIL directed[%0d] freq %h: got %h busy %0d expected %h busy 1",
                 i, fin[i], observed(), busy, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] fin;
    logic [8:0]  exp;
    int lat;
    bit got, busy;
    for (int i = 0; i < 250; i++) begin
      case (i % 3)
        0: fin = $urandom;
        1: fin = $urandom >> $urandom_range(1, 12);
        default: fin = (TB_T[$urandom_range(0, 11)] >> $urandom_range(0, 9)) +
                       32'($urandom_range(0, 4)) - 32'd2;
      endcase
      exp = ref_note(fin);
      convert(fin, lat, got, busy);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL random_timeout: no note_valid for %h", fin);
      end else if (observed() !== exp || done !== 1'b1 || lat > 21) begin
        errors++;
        $display("FAIL random freq %h: got %h done %0b lat %0d expected %h done 1 lat<=21",
                 fin, observed(), done, lat, exp);
      end
    end
  endtask

  task automatic test_restart();
    int pulses = 0;
    logic [8:0] res = '0;
    @(negedge clk);
    freq_in = 32'h1B800000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    freq_in = 32'h1BD00000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (note_valid) begin
        pulses++;
        res = observed();
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1 || res !== ref_note(32'h1BD00000) || res[1] !== 1'b1) begin
      errors++;
      $display("FAIL restart: pulses %0d result %h expected 1 pulse result %h",
               pulses, res, ref_note(32'h1BD00000));
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    freq_in = 32'h1B800000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 9'd0 || done !== 1'b1 || note_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h done %0b valid %0b expected 000 done 1 valid 0",
               observed(), done, note_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (note_valid) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: pulses %0d done %0b expected 0 pulses done 1", pulses, done);
    end
  endtask

  task automatic test_handshake();
    int lat, bad = 0;
    bit got, busy;
    logic [8:0] held;
    convert(32'h1CC00000, lat, got, busy);
    held = observed();
    checks++;
    if (!got || held !== ref_note(32'h1CC00000)) begin
      errors++;
      $display("FAIL handshake_result: got %h expected %h", held, ref_note(32'h1CC00000));
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (observed() !== held || done !== 1'b1 || note_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL handshake_hold: %0d of 100 idle cycles changed, expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat, t;
    bit got, busy;
    logic [8:0] first_res;
    convert(32'h1B800000, lat, got, busy);
    checks++;
    if (!got || lat < 2) begin
      errors++;
      $display("FAIL b2b_measure: got %0d lat %0d expected pulse with lat>=2", got, lat);
      return;
    end
    @(negedge clk);
    freq_in = 32'h1B800000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < lat - 1; i++) @(negedge clk);
    freq_in = 32'h1CC00000;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    first_res = observed();
    checks++;
    if (note_valid !== 1'b1 || done !== 1'b0 || first_res !== ref_note(32'h1B800000)) begin
      errors++;
      $display("FAIL b2b_first: valid %0b done %0b result %h expected valid 1 done 0 result %h",
               note_valid, done, first_res, ref_note(32'h1B800000));
    end
    t = 0;
    @(negedge clk);
    while (!note_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!note_valid || observed() !== ref_note(32'h1CC00000) || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: valid %0b result %h done %0b expected valid 1 result %h done 1",
               note_valid, observed(), done, ref_note(32'h1CC00000));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    freq_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    test_handshake();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
